// File: rtl/sbus_pkg.sv
// Shared types and default widths for the S-bus write-burst controller.
package sbus_pkg;

  localparam int unsigned SBUS_ADDR_W = 48;
  localparam int unsigned SBUS_DATA_W = 176;
  localparam int unsigned SBUS_CNT_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLoad,
    StReq,
    StDone
  } sbus_wburst_state_t;

endpackage

// File: rtl/sbus_ack_timer.sv
// Counts cycles spent waiting for Swack; expired is asserted on the AckTimeout-th enabled cycle.
module sbus_ack_timer #(
  parameter int unsigned AckTimeout = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned TW = $clog2(AckTimeout + 1);

  logic [TW-1:0] count_q, count_d;

  assign expired_o = enable_i && (count_q == TW'(AckTimeout - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sbus_wburst_ctrl.sv
// S-bus write-burst controller: pops one FIFO entry per word and writes it with a request/ack handshake.
// Optional ack timeout enabled by defining SBUS_WTIMEOUT_EN.
module sbus_wburst_ctrl
  import sbus_pkg::*;
#(
  parameter int unsigned ADDR_W      = SBUS_ADDR_W,
  parameter int unsigned DATA_W      = SBUS_DATA_W,
  parameter int unsigned CNT_W       = SBUS_CNT_W,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic              Sclk,
  input  logic              Sreset,
  input  logic              start,
  input  logic [CNT_W-1:0]  numwords,
  input  logic              wrequest,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              Swack,
  output logic              Swrequest,
  output logic [ADDR_W-1:0] Swaddr,
  output logic [DATA_W-1:0] Swdata,
  output logic              fifo_read,
  output logic              incr_store_addr,
  output logic [CNT_W-1:0]  words_sent,
  output logic              busy,
  output logic              done,
  output logic              error
);

  sbus_wburst_state_t state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   sent_q, sent_d, sent_inc;
  logic               swreq_q, swreq_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               pop, incr;
  logic               timeout;

`ifdef SBUS_WTIMEOUT_EN
  sbus_ack_timer #(
    .AckTimeout(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_i    (Sclk),
    .rst_i    (Sreset),
    .clear_i  (state_q == StLoad),
    .enable_i (state_q == StReq),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A zero timeout would abort every word before it could be acked.
  a_timeout_nonzero : assert property (@(posedge Sclk) ACK_TIMEOUT > 0);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    sent_d   = sent_q;
    swreq_d  = swreq_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    pop      = 1'b0;
    incr     = 1'b0;
    sent_inc = sent_q + CNT_W'(1);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = numwords;
          sent_d  = '0;
          err_d   = 1'b0;
          state_d = (numwords == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        if (wrequest) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        addr_d  = waddr;
        data_d  = wdata;
        swreq_d = 1'b1;
        state_d = StReq;
      end
      StReq: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (Swack) begin
          swreq_d = 1'b0;
          sent_d  = sent_inc;
          if (sent_inc == len_q) begin
            state_d = StDone;
          end else begin
            incr    = 1'b1;
            state_d = StFill;
          end
        end else if (timeout) begin
          swreq_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Sclk) begin
    if (Sreset) begin
      state_q <= StIdle;
      len_q   <= '0;
      sent_q  <= '0;
      swreq_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      swreq_q <= swreq_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Pulses are suppressed while reset is held so an abandoned burst emits nothing.
  assign fifo_read       = pop && !Sreset;
  assign incr_store_addr = incr && !Sreset;
  assign Swrequest       = swreq_q;
  assign Swaddr          = addr_q;
  assign Swdata          = data_q;
  assign words_sent      = sent_q;
  assign busy            = (state_q == StFill) || (state_q == StLoad) || (state_q == StReq);
  assign done            = (state_q == StDone);
  assign error           = err_q;

endmodule

// File: tb/tb_sbus_wburst_ctrl.sv
// Scoreboard bench for sbus_wburst_ctrl: FIFO model feeds random words, monitor checks each S-bus write.
module tb_sbus_wburst_ctrl;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 176;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMO    = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              Sreset, start, wrequest, Swack;
  logic [CNT_W-1:0]  numwords;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              Swrequest, fifo_read, incr_store_addr, busy, done, error;
  logic [ADDR_W-1:0] Swaddr;
  logic [DATA_W-1:0] Swdata;
  logic [CNT_W-1:0]  words_sent;

  sbus_wburst_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ACK_TIMEOUT(TMO)
  ) dut (
    .Sclk(clk), .Sreset(Sreset), .start(start), .numwords(numwords), .wrequest(wrequest),
    .waddr(waddr), .wdata(wdata), .Swack(Swack), .Swrequest(Swrequest), .Swaddr(Swaddr),
    .Swdata(Swdata), .fifo_read(fifo_read), .incr_store_addr(incr_store_addr),
    .words_sent(words_sent), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  wr_t fifo_q[$];
  wr_t exp_q[$];
  int  n_cmp = 0, n_err = 0;
  int  fifo_cnt, incr_cnt, req_cycles, busy_cycles, acked_cnt;
  int  ack_limit = 1 << 30, ack_fixed = -1, max_ack = 0, gap_pct = 0;
  int  ack_wait = 0, ack_delay = 0;
  bit  pop_pending = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] rbits();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // FIFO and S-bus slave model, driven just after each rising edge.
  initial begin
    logic [191:0] r;
    wr_t e;
    wrequest = 1'b0;
    Swack    = 1'b0;
    waddr    = '0;
    wdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() > 0) begin
        e = fifo_q.pop_front();
        waddr = e.a;
        wdata = e.d;
      end else begin
        r = rbits();
        waddr = r[ADDR_W-1:0];
        r = rbits();
        wdata = r[DATA_W-1:0];
      end
      pop_pending = 1'b0;
      wrequest = (fifo_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
      if (Swrequest && acked_cnt < ack_limit) begin
        if (ack_wait >= ack_delay) begin
          Swack = 1'b1;
        end else begin
          Swack = 1'b0;
          ack_wait++;
        end
      end else begin
        // Stray acks while no request is pending must be ignored by the DUT.
        Swack     = !Swrequest && ($urandom_range(0, 3) == 0);
        ack_wait  = 0;
        ack_delay = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, max_ack));
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!Sreset) begin
        if (fifo_read) begin
          pop_pending = 1'b1;
          fifo_cnt++;
        end
        if (Swrequest) req_cycles++;
        if (busy) busy_cycles++;
        if (busy && done) check("busy_done_exclusive", 1, 0);
        if (incr_store_addr) check("incr_with_ack", {Swrequest, Swack}, 2'b11);
        if (incr_store_addr) incr_cnt++;
        if (Swrequest && prev_req && !prev_ack) begin
          check("swaddr_stable", Swaddr, prev_addr);
          check("swdata_stable", Swdata, prev_data);
        end
        if (Swrequest && Swack) begin
          acked_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", Swaddr, e.a);
            check("write_data", Swdata, e.d);
          end
        end
      end
      prev_req  = Swrequest && !Sreset;
      prev_ack  = Swack;
      prev_addr = Swaddr;
      prev_data = Swdata;
    end
  end

  task automatic load_burst(input int n);
    logic [191:0] r;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      r = rbits();
      e.a = r[ADDR_W-1:0];
      r = rbits();
      e.d = r[DATA_W-1:0];
      fifo_q.push_back(e);
      exp_q.push_back(e);
    end
    fifo_cnt = 0; incr_cnt = 0; req_cycles = 0; busy_cycles = 0; acked_cnt = 0;
  endtask

  task automatic start_and_wait(input int n, output int cyc, output bit ok);
    @(posedge clk);
    #1;
    start    = 1'b1;
    numwords = CNT_W'(n);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic end_burst();
    repeat (2) @(negedge clk);
    check("done_held_while_start", done, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  task automatic run_normal(input int n);
    int cyc;
    bit ok;
    load_burst(n);
    start_and_wait(n, cyc, ok);
    if (ok) begin
      check("words_sent", words_sent, n);
      check("fifo_reads", fifo_cnt, n);
      check("incr_pulses", incr_cnt, (n > 0) ? n - 1 : 0);
      check("writes_left", exp_q.size(), 0);
      check("busy_cycles", busy_cycles, cyc - 2);
      check("error_clear", error, 0);
      check("swreq_low_at_done", Swrequest, 0);
    end
    end_burst();
  endtask

  initial begin
    int cyc;
    bit ok;
    Sreset   = 1'b1;
    start    = 1'b0;
    numwords = '0;
    repeat (3) @(posedge clk);
    #1;
    Sreset = 1'b0;
    @(negedge clk);
    check("rst_outputs",
          {Swrequest, Swaddr, Swdata, fifo_read, incr_store_addr, words_sent, busy, done, error}, 0);

    ack_fixed = 0;
    run_normal(3);

    load_burst(0);
    start_and_wait(0, cyc, ok);
    check("zero_len_latency", cyc - 1, 1);
    check("zero_len_no_req", {req_cycles, fifo_cnt}, 0);
    end_burst();

    ack_fixed = 5;
    gap_pct   = 60;
    run_normal(4);

    // Reset while word 2 of 4 waits for its ack.
    ack_fixed = 0;
    gap_pct   = 0;
    load_burst(4);
    ack_limit = 1;
    @(posedge clk);
    #1;
    start    = 1'b1;
    numwords = CNT_W'(4);
    cyc = 0;
    while (cyc < 200 && !(acked_cnt == 1 && Swrequest)) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_word2_req", {acked_cnt == 1, Swrequest}, 2'b11);
    @(posedge clk);
    #1;
    Sreset = 1'b1;
    start  = 1'b0;
    @(posedge clk);
    #1;
    Sreset = 1'b0;
    @(negedge clk);
    check("midburst_rst_outputs",
          {Swrequest, Swaddr, Swdata, fifo_read, incr_store_addr, words_sent, busy, done, error}, 0);
    fifo_q.delete();
    exp_q.delete();
    ack_limit = 1 << 30;
    run_normal(4);

    ack_fixed = -1;
    for (int i = 0; i < 8; i++) begin
      max_ack = $urandom_range(0, 5);
      gap_pct = $urandom_range(0, 70);
      run_normal($urandom_range(1, 12));
    end

`ifdef SBUS_WTIMEOUT_EN
    gap_pct   = 0;
    ack_limit = 0;
    load_burst(1);
    start_and_wait(1, cyc, ok);
    check("tmo_req_cycles", req_cycles, TMO);
    check("tmo_flags", {error, done, Swrequest}, 3'b110);
    check("tmo_words_sent", words_sent, 0);
    check("tmo_no_incr", incr_cnt, 0);
    end_burst();
    check("tmo_error_sticky", error, 1);
    exp_q.delete();
    ack_limit = 1 << 30;
    ack_fixed = TMO - 1;
    load_burst(2);
    start_and_wait(2, cyc, ok);
    check("expiry_ack_words", words_sent, 2);
    check("expiry_ack_error", error, 0);
    check("expiry_ack_req_cycles", req_cycles, 2 * TMO);
    end_burst();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
